// File: rtl/sync_down_counter_pkg.sv
// Shared types and constants for the loadable down counter.
package sync_down_counter_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Operating modes captured alongside a load.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sync_down_counter_down_tff_cell.sv
// One bit of the down-counter datapath: a toggle flop with synchronous
// clear and parallel load, updating on the falling clock edge.
module down_tff_cell
  import sync_down_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;

  // Clear beats load, load beats toggle.
  always_ff @(negedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (ld) begin
      q_q <= d;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with terminal-count pulse and a
// one-shot / periodic control FSM. All state changes on the falling edge.
// Optional cascade ports (cin/cout) are enabled by defining the macro
// SYNC_DOWN_COUNTER_CASCADE_EN.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
`ifdef SYNC_DOWN_COUNTER_CASCADE_EN
  input  logic             cin,
  output logic             cout,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tc_q, tc_d;

  logic             cnt_en;
  logic             is_run;
  logic             q_zero;
  logic             q_one;
  logic             step_dec;
  logic             reload_hit;
  logic             bit_ld;
  logic [WIDTH-1:0] bit_d;
  logic [WIDTH-1:0] zero_below;
  logic [WIDTH-1:0] q_bits;

`ifdef SYNC_DOWN_COUNTER_CASCADE_EN
  assign cnt_en = en & cin;
`else
  assign cnt_en = en;
`endif

  assign is_run = (state_q == RUN);
  assign q_zero = ~|q_bits;
  assign q_one  = (q_bits == WIDTH'(1));

  // A decrement happens only in RUN with a nonzero count and no load;
  // at zero a periodic counter reloads instead of wrapping.
  assign step_dec   = ~load & is_run & cnt_en & ~q_zero;
  assign reload_hit = ~load & is_run & cnt_en & q_zero & (mode_q == MODE_PERIODIC);

  assign bit_ld = load | reload_hit;
  assign bit_d  = load ? load_val : reload_q;

  // Borrow lookahead: bit i toggles when every lower bit is zero.
  assign zero_below[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_borrow
      assign zero_below[gi] = zero_below[gi-1] & ~q_bits[gi-1];
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      down_tff_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .t     (step_dec & zero_below[gi]),
        .ld    (bit_ld),
        .d     (bit_d[gi]),
        .q     (q_bits[gi])
      );
    end
  endgenerate

  // Reload value and mode are captured only by a load.
  always_ff @(negedge clk) begin
    if (reset) begin
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else if (load) begin
      reload_q <= load_val;
      mode_q   <= mode;
    end
  end

  // State and terminal-count registers.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state and terminal-count decode.
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    if (load) begin
      state_d = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_en) begin
            if (q_one) begin
              tc_d = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_d = DONE;
              end
            end else if (q_zero && (mode_q == MODE_ONESHOT)) begin
              // Unreachable in normal use; park rather than wrap.
              state_d = DONE;
            end
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign q    = q_bits;
  assign tc   = tc_q;
  assign busy = is_run;

`ifdef SYNC_DOWN_COUNTER_CASCADE_EN
  assign cout = cnt_en & is_run & q_zero;
`endif

endmodule
